qos_interconnect_param: RTL

Parametrised successor of the two-VC, two-destination PCIe QoS interconnect. One ingress FIFO is demultiplexed by the VC field into NUM_VC virtual-channel FIFOs. A selectable strict-priority or round-robin arbiter drains the VC FIFOs into NUM_DEST destination FIFOs, routed by the destination field. Threshold-based backpressure prevents overflow in normal operation; sticky per-FIFO error flags catch any overflow or underflow that still occurs.

---
 rtl/qos_interconnect_pkg.sv | 43 ++++
 rtl/qos_interconnect_param_fifo.sv | 65 ++++++
 rtl/qos_interconnect_param.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/qos_interconnect_pkg.sv
// Shared constants and helpers for the parametrised QoS interconnect.
package qos_interconnect_pkg;

    localparam int ARB_STRICT   = 0;
    localparam int ARB_RR       = 1;

    localparam int ERR_MAIN_IDX = 0;
    localparam int ERR_VC_BASE  = 1;

    // A field selecting among n items needs at least one bit, even when n is 1.
    function automatic int field_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int vc_width(input int num_vc);
        return field_width(num_vc);
    endfunction

    function automatic int dest_width(input int num_dest);
        return field_width(num_dest);
    endfunction

    // Destination error bits sit directly above the VC error bits.
    function automatic int err_dest_base(input int num_vc);
        return ERR_VC_BASE + num_vc;
    endfunction

    // Destination field occupies the top dest_w bits of a bw-bit word.
    function automatic int get_dest(input logic [31:0] word, input int bw, input int dest_w);
        logic [31:0] mask;
        mask = (32'd1 << dest_w) - 32'd1;
        return int'((word >> (bw - dest_w)) & mask);
    endfunction

    // VC field occupies the vc_w bits directly below the destination field.
    function automatic int get_vc(input logic [31:0] word, input int bw, input int dest_w,
                                  input int vc_w);
        logic [31:0] mask;
        mask = (32'd1 << vc_w) - 32'd1;
        return int'((word >> (bw - dest_w - vc_w)) & mask);
    endfunction

endpackage

// File: rtl/qos_interconnect_param_fifo.sv
// First-word-fall-through FIFO with registered count, thresholds and a sticky error flag.
module qos_fifo_sync
    import qos_interconnect_pkg::*;
#(
    parameter int BW    = 6,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr,
    input  logic [BW-1:0]                  data_in,
    input  logic                           rd,
    input  logic [$clog2(DEPTH+1)-1:0]     umbral_high,
    input  logic [$clog2(DEPTH+1)-1:0]     umbral_low,
    output logic [BW-1:0]                  data_out,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= umbral_high);
    assign almost_empty = (count <= umbral_low);
    assign data_out     = empty ? '0 : mem[rd_ptr];

    // A write to a full FIFO is dropped even if a pop frees a slot in the same cycle.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    // Storage, pointers, count and the sticky overflow/underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
            if ((wr && full) || (rd && empty)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_interconnect_param.sv
// Ingress FIFO -> per-VC FIFOs -> arbiter -> per-destination FIFOs.
module qos_interconnect_param
    import qos_interconnect_pkg::*;
#(
    parameter int BW         = 6,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int MAIN_DEPTH = 4,
    parameter int VC_DEPTH   = 16,
    parameter int DEST_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 main_wr,
    input  logic [BW-1:0]                        main_data_in,
    output logic                                 main_full,
    output logic                                 main_empty,
    input  logic [$clog2(MAIN_DEPTH+1)-1:0]      umbral_main_high,
    input  logic [$clog2(MAIN_DEPTH+1)-1:0]      umbral_main_low,
    input  logic [$clog2(VC_DEPTH+1)-1:0]        umbral_vc_high,
    input  logic [$clog2(VC_DEPTH+1)-1:0]        umbral_vc_low,
    input  logic [$clog2(DEST_DEPTH+1)-1:0]      umbral_dest_high,
    input  logic [$clog2(DEST_DEPTH+1)-1:0]      umbral_dest_low,
    input  logic [NUM_DEST-1:0]                  dest_rd,
    output logic [NUM_DEST*BW-1:0]               dest_data_out,
    output logic [NUM_DEST-1:0]                  dest_empty,
    output logic [NUM_DEST-1:0]                  dest_almost_full,
    output logic [NUM_VC-1:0]                    vc_empty,
    output logic [NUM_VC+NUM_DEST:0]             error_output
);

    localparam int VC_W   = vc_width(NUM_VC);
    localparam int DEST_W = dest_width(NUM_DEST);

    // Out-of-range field values fold onto the last VC / destination.
    function automatic logic [VC_W-1:0] route_vc(input logic [BW-1:0] word);
        int v;
        v = get_vc(32'(word), BW, DEST_W, VC_W);
        if (v >= NUM_VC) v = NUM_VC - 1;
        return VC_W'(v);
    endfunction

    function automatic logic [DEST_W-1:0] route_dest(input logic [BW-1:0] word);
        int d;
        d = get_dest(32'(word), BW, DEST_W);
        if (d >= NUM_DEST) d = NUM_DEST - 1;
        return DEST_W'(d);
    endfunction

    logic [BW-1:0]     main_head;
    logic              main_af, main_ae;
    logic [VC_W-1:0]   head_vc;
    logic              main_pop;

    logic              s1_valid;
    logic [BW-1:0]     s1_data;
    logic [VC_W-1:0]   s1_vc;

    logic [BW-1:0]     vc_head [NUM_VC];
    logic [NUM_VC-1:0] vc_af, vc_ae, vc_full, vc_rd, vc_eligible;
    logic [DEST_W-1:0] vc_dest [NUM_VC];

    logic [NUM_DEST-1:0] dest_ae, dest_full;

    logic              grant_valid;
    logic [VC_W-1:0]   grant_idx;
    logic [VC_W-1:0]   rr_ptr;
    int                scan;

    logic              s2_valid;
    logic [BW-1:0]     s2_data;
    logic [DEST_W-1:0] s2_dest;

    logic              unused_status;

    qos_fifo_sync #(.BW(BW), .DEPTH(MAIN_DEPTH)) u_main (
        .clk(clk), .reset(reset), .wr(main_wr), .data_in(main_data_in), .rd(main_pop),
        .umbral_high(umbral_main_high), .umbral_low(umbral_main_low),
        .data_out(main_head), .full(main_full), .empty(main_empty),
        .almost_full(main_af), .almost_empty(main_ae), .error(error_output[ERR_MAIN_IDX])
    );

    // Ingress pops only if its VC has room and is not already being fed by the stage register.
    assign head_vc  = route_vc(main_head);
    assign main_pop = !main_empty && !vc_af[head_vc] && !(s1_valid && (s1_vc == head_vc));

    // Stage register between the ingress FIFO and the VC FIFOs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_vc    <= '0;
        end else begin
            s1_valid <= main_pop;
            s1_data  <= main_head;
            s1_vc    <= head_vc;
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        qos_fifo_sync #(.BW(BW), .DEPTH(VC_DEPTH)) u_vc (
            .clk(clk), .reset(reset), .wr(s1_valid && (s1_vc == VC_W'(i))), .data_in(s1_data),
            .rd(vc_rd[i]), .umbral_high(umbral_vc_high), .umbral_low(umbral_vc_low),
            .data_out(vc_head[i]), .full(vc_full[i]), .empty(vc_empty[i]),
            .almost_full(vc_af[i]), .almost_empty(vc_ae[i]),
            .error(error_output[ERR_VC_BASE + i])
        );
        assign vc_rd[i] = grant_valid && (grant_idx == VC_W'(i));
    end

    // A VC may compete only if its head word's destination can accept it.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_dest[i]     = route_dest(vc_head[i]);
            vc_eligible[i] = !vc_empty[i] && !dest_almost_full[vc_dest[i]]
                             && !(s2_valid && (s2_dest == vc_dest[i]));
        end
    end

    // Pick the first eligible VC, scanning from 0 (strict) or from rr_ptr (round-robin).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (ARB_MODE == ARB_RR) scan = (int'(rr_ptr) + k) % NUM_VC;
            else                    scan = k;
            if (!grant_valid && vc_eligible[VC_W'(scan)]) begin
                grant_valid = 1'b1;
                grant_idx   = VC_W'(scan);
            end
        end
    end

    // Stage register between the arbiter and the destination FIFOs, plus the rotation pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_dest  <= '0;
            rr_ptr   <= '0;
        end else begin
            s2_valid <= grant_valid;
            s2_data  <= vc_head[grant_idx];
            s2_dest  <= vc_dest[grant_idx];
            if (grant_valid) begin
                rr_ptr <= VC_W'((int'(grant_idx) + 1) % NUM_VC);
            end
        end
    end

    for (genvar j = 0; j < NUM_DEST; j++) begin : g_dest
        qos_fifo_sync #(.BW(BW), .DEPTH(DEST_DEPTH)) u_dest (
            .clk(clk), .reset(reset), .wr(s2_valid && (s2_dest == DEST_W'(j))), .data_in(s2_data),
            .rd(dest_rd[j]), .umbral_high(umbral_dest_high), .umbral_low(umbral_dest_low),
            .data_out(dest_data_out[j*BW +: BW]), .full(dest_full[j]), .empty(dest_empty[j]),
            .almost_full(dest_almost_full[j]), .almost_empty(dest_ae[j]),
            .error(error_output[err_dest_base(NUM_VC) + j])
        );
    end

    assign unused_status = ^{main_af, main_ae, vc_ae, vc_full, dest_ae, dest_full};

endmodule
